// File: rtl/cfg_loader.sv
// -----------------------------------------------------------------------------
// cfg_loader
// Frames configuration packets from the UART byte stream and commits them
// atomically to the active parameter bank. A packet is HEADER, PAR_NUM
// parameter bytes, then a checksum byte (sum of the parameter bytes mod 256).
// A validated packet is held in a shadow bank and copied to cfg_par in a
// single edge once the bridge driver reports idle, so the power stage never
// sees a half-updated parameter set.
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   byte_data    received byte, qualified by byte_valid
//   byte_valid   one-cycle strobe per received byte
//   drv_busy     1 = bridge switching, commit deferred
//   cfg_par      active parameter bank, byte i at [8i+7:8i]
//   cfg_valid    sticky, set by the first commit after reset
//   cfg_update   one-cycle pulse when cfg_par takes new values
//   err_cksum    one-cycle pulse on checksum mismatch
//   err_timeout  one-cycle pulse on inter-byte timeout
//   err_overrun  one-cycle pulse when a byte is dropped while awaiting commit
// -----------------------------------------------------------------------------
module cfg_loader #(
    parameter int unsigned PAR_NUM     = 5,
    parameter logic [7:0]  HEADER      = 8'hA5,
    parameter int unsigned TIMEOUT_MAX = 16000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             byte_data,
    input  logic                   byte_valid,
    input  logic                   drv_busy,
    output logic [PAR_NUM*8-1:0]   cfg_par,
    output logic                   cfg_valid,
    output logic                   cfg_update,
    output logic                   err_cksum,
    output logic                   err_timeout,
    output logic                   err_overrun
);

    localparam int unsigned      IDX_W    = $clog2(PAR_NUM + 1);
    localparam int unsigned      TMO_W    = $clog2(TIMEOUT_MAX + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAR_NUM - 1);
    // Expiry is flagged on the idle cycle that would bring tmo to TIMEOUT_MAX,
    // so the error pulse lands on the edge that processes that cycle.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_MAX - 1);

    typedef enum logic [1:0] {
        S_HUNT,
        S_DATA,
        S_CKSUM,
        S_WAIT
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [7:0]           r_shadow [PAR_NUM];
    logic [IDX_W-1:0]     r_idx;
    logic [7:0]           r_sum;
    logic [TMO_W-1:0]     r_tmo;

    logic [PAR_NUM*8-1:0] r_cfg_par;
    logic                 r_cfg_valid;
    logic                 r_cfg_update;
    logic                 r_err_cksum;
    logic                 r_err_timeout;
    logic                 r_err_overrun;

    logic                 w_open;
    logic                 w_expire;
    logic                 w_last;
    logic                 w_start;
    logic                 w_store;
    logic                 w_commit;
    logic                 w_err_cksum;
    logic                 w_err_timeout;
    logic                 w_err_overrun;

    assign w_open   = (r_state == S_DATA) || (r_state == S_CKSUM);
    // A strobe on the expiry cycle wins, hence the !byte_valid term.
    assign w_expire = w_open && !byte_valid && (r_tmo == TMO_LAST);
    assign w_last   = (r_idx == IDX_LAST);

    // ---------------------------------------------------------------- state reg
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_HUNT;
        else        r_state <= w_next_state;
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        // NOTE: default assignment first so no path leaves w_next_state
        // unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        case (r_state)
            S_HUNT:  if (byte_valid && byte_data == HEADER) w_next_state = S_DATA;
            S_DATA: begin
                if (byte_valid) begin
                    if (w_last) w_next_state = S_CKSUM;
                end else if (w_expire) begin
                    w_next_state = S_HUNT;
                end
            end
            S_CKSUM: begin
                if (byte_valid)    w_next_state = (byte_data == r_sum) ? S_WAIT : S_HUNT;
                else if (w_expire) w_next_state = S_HUNT;
            end
            S_WAIT:  if (!drv_busy) w_next_state = S_HUNT;
            default: w_next_state = S_HUNT;
        endcase
    end

    // ------------------------------------------------------------- output comb
    // A byte arriving on the commit cycle is discarded without an overrun
    // pulse, keeping cfg_update and the error pulses mutually exclusive.
    always_comb begin
        w_start       = (r_state == S_HUNT)  && byte_valid && (byte_data == HEADER);
        w_store       = (r_state == S_DATA)  && byte_valid;
        w_commit      = (r_state == S_WAIT)  && !drv_busy;
        w_err_overrun = (r_state == S_WAIT)  && drv_busy && byte_valid;
        w_err_cksum   = (r_state == S_CKSUM) && byte_valid && (byte_data != r_sum);
        w_err_timeout = w_expire;
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the shadow bank is plain flops, so it is cleared with the
            // rest; a packet interrupted by reset leaves nothing behind.
            for (int i = 0; i < int'(PAR_NUM); i++) r_shadow[i] <= '0;
            r_idx         <= '0;
            r_sum         <= '0;
            r_tmo         <= '0;
            r_cfg_par     <= '0;
            r_cfg_valid   <= 1'b0;
            r_cfg_update  <= 1'b0;
            r_err_cksum   <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_cfg_update  <= w_commit;
            r_err_cksum   <= w_err_cksum;
            r_err_timeout <= w_err_timeout;
            r_err_overrun <= w_err_overrun;

            if (w_start) begin
                r_idx <= '0;
                r_sum <= '0;
            end

            if (w_store) begin
                for (int i = 0; i < int'(PAR_NUM); i++) begin
                    if (r_idx == IDX_W'(i)) r_shadow[i] <= byte_data;
                end
                r_sum <= r_sum + byte_data;
                if (!w_last) r_idx <= r_idx + IDX_W'(1);
            end

            // Counts idle cycles only while a packet is open; any strobe,
            // expiry or leaving the packet clears it.
            if (w_open && !byte_valid && !w_expire) r_tmo <= r_tmo + TMO_W'(1);
            else                                    r_tmo <= '0;

            if (w_commit) begin
                for (int i = 0; i < int'(PAR_NUM); i++) r_cfg_par[8*i +: 8] <= r_shadow[i];
                r_cfg_valid <= 1'b1;
            end
        end
    end

    assign cfg_par     = r_cfg_par;
    assign cfg_valid   = r_cfg_valid;
    assign cfg_update  = r_cfg_update;
    assign err_cksum   = r_err_cksum;
    assign err_timeout = r_err_timeout;
    assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_cfg_loader
// Directed and randomized stimulus for cfg_loader. A packet-level reference
// model predicts, per input cycle, which event (commit, checksum error,
// timeout, overrun, reset) must appear on the outputs one edge later and
// queues it; a monitor on the falling edge pops and compares every cycle.
// -----------------------------------------------------------------------------
module tb_cfg_loader;

    localparam int          PAR_NUM = 5;
    localparam int          TMO     = 20;
    localparam logic [7:0]  HDR     = 8'hA5;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [7:0]           byte_data;
    logic                 byte_valid;
    logic                 drv_busy;
    logic [PAR_NUM*8-1:0] cfg_par;
    logic                 cfg_valid;
    logic                 cfg_update;
    logic                 err_cksum;
    logic                 err_timeout;
    logic                 err_overrun;

    always #5 clk = ~clk;

    cfg_loader #(
        .PAR_NUM     (PAR_NUM),
        .HEADER      (HDR),
        .TIMEOUT_MAX (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .drv_busy    (drv_busy),
        .cfg_par     (cfg_par),
        .cfg_valid   (cfg_valid),
        .cfg_update  (cfg_update),
        .err_cksum   (err_cksum),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    typedef enum int {EV_COMMIT, EV_CKSUM, EV_TMO, EV_OVR, EV_RESET} ev_kind_t;
    typedef struct {
        ev_kind_t             kind;
        int                   stamp;
        logic [PAR_NUM*8-1:0] par;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    bit  mon_on = 1'b0;

    // ---------------------------------------------------------- check helper
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------ reference model
    // Packet-level view: an open packet is a growing list of bytes; once it
    // holds PAR_NUM bytes the next byte is the checksum.
    bit                   m_open = 1'b0;
    bit                   m_pend = 1'b0;
    logic [7:0]           m_bytes[$];
    int                   m_idle = 0;
    logic [PAR_NUM*8-1:0] m_pend_par = '0;

    function automatic void push_ev(ev_kind_t k, logic [PAR_NUM*8-1:0] p);
        ev_t e;
        e.kind  = k;
        e.stamp = cyc;
        e.par   = p;
        exp_q.push_back(e);
    endfunction

    function automatic void model_cycle();
        if (!rst_n) begin
            m_open = 1'b0;
            m_pend = 1'b0;
            m_bytes.delete();
            m_idle = 0;
            push_ev(EV_RESET, '0);
            return;
        end
        if (m_pend) begin
            if (!drv_busy) begin
                push_ev(EV_COMMIT, m_pend_par);
                m_pend = 1'b0;
            end else if (byte_valid) begin
                push_ev(EV_OVR, '0);
            end
        end else if (!m_open) begin
            if (byte_valid && byte_data == HDR) begin
                m_open = 1'b1;
                m_bytes.delete();
                m_idle = 0;
            end
        end else if (byte_valid) begin
            m_idle = 0;
            if (m_bytes.size() < PAR_NUM) begin
                m_bytes.push_back(byte_data);
            end else begin
                int s;
                s = 0;
                foreach (m_bytes[i]) s += int'(m_bytes[i]);
                m_open = 1'b0;
                if (byte_data == 8'(s % 256)) begin
                    m_pend = 1'b1;
                    foreach (m_bytes[i]) m_pend_par[8*i +: 8] = m_bytes[i];
                end else begin
                    push_ev(EV_CKSUM, '0);
                end
            end
        end else begin
            m_idle++;
            if (m_idle == TMO) begin
                m_open = 1'b0;
                push_ev(EV_TMO, '0);
            end
        end
    endfunction

    // -------------------------------------------------------------- drivers
    task automatic tick(input logic v, input logic [7:0] d);
        byte_valid = v;
        byte_data  = v ? d : 8'($urandom);
        model_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00);
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        idle(gap);
        tick(1'b1, d);
    endtask

    task automatic send_frame(input logic [7:0] p[PAR_NUM], input logic [7:0] ck);
        send_byte(HDR, 0);
        foreach (p[i]) send_byte(p[i], 0);
        send_byte(ck, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
    endtask

    function automatic int rgap();
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0) return int'($urandom_range(TMO - 2, TMO + 2));
        if (r < 8)  return 0;
        return int'($urandom_range(1, 3));
    endfunction

    task automatic rand_pkt();
        logic [7:0] p[PAR_NUM];
        logic [7:0] ck;
        int         s;
        s = 0;
        foreach (p[i]) begin
            p[i] = 8'($urandom);
            s += int'(p[i]);
        end
        ck = 8'(s);
        if ($urandom_range(0, 3) == 0) ck = ck ^ 8'($urandom_range(1, 255));
        send_byte(HDR, rgap());
        foreach (p[i]) send_byte(p[i], rgap());
        send_byte(ck, rgap());
    endtask

    // --------------------------------------------------------------- monitor
    logic [PAR_NUM*8-1:0] sb_par   = '0;
    logic                 sb_valid = 1'b0;

    initial begin
        wait (mon_on);
        forever begin
            logic [3:0] ep;
            int         now;
            ev_t        e;
            @(negedge clk);
            now = cyc - 1;
            ep  = 4'b0000;
            if (exp_q.size() > 0 && exp_q[0].stamp == now) begin
                e = exp_q.pop_front();
                case (e.kind)
                    EV_COMMIT: begin
                        ep       = 4'b1000;
                        sb_par   = e.par;
                        sb_valid = 1'b1;
                    end
                    EV_CKSUM:  ep = 4'b0100;
                    EV_TMO:    ep = 4'b0010;
                    EV_OVR:    ep = 4'b0001;
                    EV_RESET: begin
                        sb_par   = '0;
                        sb_valid = 1'b0;
                    end
                    default:   ep = 4'b0000;
                endcase
            end
            check("pulses(upd,cks,tmo,ovr)",
                  64'({cfg_update, err_cksum, err_timeout, err_overrun}), 64'(ep));
            check("cfg_par", 64'(cfg_par), 64'(sb_par));
            check("cfg_valid", 64'(cfg_valid), 64'(sb_valid));
        end
    end

    // -------------------------------------------------------------- stimulus
    logic [7:0] pk[PAR_NUM];

    initial begin
        rst_n      = 1'b0;
        drv_busy   = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;

        idle(1);
        mon_on = 1'b1;
        idle(1);
        rst_n = 1'b1;
        idle(2);

        // Nominal packet, commit two edges after the checksum strobe.
        pk = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_frame(pk, 8'h0F);
        idle(3);
        check("nominal_par", 64'(cfg_par), 64'h05_0403_0201);
        check("nominal_valid", 64'(cfg_valid), 64'd1);

        // Bad checksum leaves the bank alone; the next good packet commits.
        pk = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_frame(pk, 8'h10);
        idle(3);
        check("badck_par", 64'(cfg_par), 64'h05_0403_0201);
        pk = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        send_frame(pk, 8'hF0);
        idle(3);
        check("after_badck_par", 64'(cfg_par), 64'h50_4030_2010);

        // Deferred commit with an overrun byte while waiting.
        drv_busy = 1'b1;
        pk = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_frame(pk, 8'hFF);
        idle(50);
        send_byte(8'h77, 0);
        idle(49);
        check("busy_hold_par", 64'(cfg_par), 64'h50_4030_2010);
        drv_busy = 1'b0;
        idle(3);
        check("deferred_par", 64'(cfg_par), 64'h55_4433_2211);

        // Timeout after TMO idle cycles, then a strobe on the expiry cycle.
        send_byte(HDR, 0);
        send_byte(8'h01, 0);
        idle(TMO);
        idle(2);
        send_byte(HDR, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, TMO - 1);
        send_byte(8'h04, 0);
        send_byte(8'h05, 0);
        send_byte(8'h06, 0);
        send_byte(8'h14, 0);
        idle(3);
        check("expiry_strobe_par", 64'(cfg_par), 64'h06_0504_0302);

        // Framing: garbage ignored, header-valued data bytes accepted.
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h13, 0);
        pk = '{HDR, HDR, HDR, HDR, HDR};
        send_frame(pk, 8'h39);
        idle(3);
        check("framing_par", 64'(cfg_par), 64'hA5_A5A5_A5A5);

        // Reset mid-packet, then reset while waiting for the driver.
        send_byte(HDR, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        do_reset();
        check("rst_par", 64'(cfg_par), 64'd0);
        check("rst_valid", 64'(cfg_valid), 64'd0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        send_byte(8'h05, 0);
        send_byte(8'h0F, 0);
        drv_busy = 1'b1;
        pk = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_frame(pk, 8'h0F);
        idle(1);
        do_reset();
        drv_busy = 1'b0;
        idle(3);
        check("rst_wait_par", 64'(cfg_par), 64'd0);
        check("rst_wait_valid", 64'(cfg_valid), 64'd0);
        pk = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E};
        send_frame(pk, 8'h3C);
        idle(3);
        check("fresh_par", 64'(cfg_par), 64'h0E_0D0C_0B0A);
        check("fresh_valid", 64'(cfg_valid), 64'd1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            int k;
            k = int'($urandom_range(0, 49));
            if (k == 0)       do_reset();
            else if (k < 6)   send_byte(8'($urandom), rgap());
            else if (k < 12)  begin drv_busy = ~drv_busy; idle(int'($urandom_range(0, 4))); end
            else              rand_pkt();
        end

        drv_busy = 1'b0;
        idle(TMO + 10);
        check("drain_queue", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
